// File: rtl/sysctrl_master.sv
// sysctrl_master: initiator for the MCU system-control byte protocol (start strobe, payload strobes, reply capture).
// Define SYSCTRL_MASTER_IRQ_SERVICE_EN to let the block service the responder interrupt on its own.
module sysctrl_master #(
    parameter int GAP    = 3,
    parameter int MAXLEN = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_cmd,
    input  logic [3:0]  req_len,
    input  logic [63:0] req_payload,
    output logic        m_strobe,
    output logic        m_start,
    output logic [7:0]  m_data,
    input  logic [7:0]  s_data,
    input  logic        s_int_n,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic [2:0]  rsp_index,
    output logic        done,
    output logic        busy,
    output logic        irq_valid,
    output logic [7:0]  irq_pending,
    output logic [7:0]  irq_src
);

    localparam int         GAP_EFF   = (GAP < 2) ? 2 : ((GAP > 15) ? 15 : GAP);
    localparam logic [3:0] WAIT_LOAD = 4'(GAP_EFF - 1);
    localparam logic [3:0] LEN_MAX   = 4'(MAXLEN);

    // IDLE | START cmd strobe | WAIT inter-strobe gap | BYTE payload strobe | DRAIN last reply flush
    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_BYTE, S_DRAIN} state_t;

    state_t       state_q, state_d;
    logic [7:0]   cmd_q, cmd_d;
    logic [3:0]   len_q, len_d;
    logic [63:0]  payload_q, payload_d;
    logic [3:0]   idx_q, idx_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         samp_q, samp_d;
    logic [2:0]   samp_idx_q, samp_idx_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic [7:0]   rsp_data_q, rsp_data_d;
    logic [2:0]   rsp_index_q, rsp_index_d;

`ifdef SYSCTRL_MASTER_IRQ_SERVICE_EN
    logic         int_meta_q, int_sync_q;
    logic         internal_q, internal_d;
    logic [1:0]   step_q, step_d;
    logic [7:0]   irq_pending_q, irq_pending_d;
    logic [7:0]   irq_src_q, irq_src_d;
    logic         irq_fire;
`endif

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        len_d       = len_q;
        payload_d   = payload_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        samp_d      = 1'b0;
        samp_idx_d  = samp_idx_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_index_d = rsp_index_q;
        req_ready   = 1'b0;
        m_strobe    = 1'b0;
        m_start     = 1'b0;
        m_data      = 8'h00;
        done        = 1'b0;
`ifdef SYSCTRL_MASTER_IRQ_SERVICE_EN
        internal_d    = internal_q;
        step_d        = step_q;
        irq_pending_d = irq_pending_q;
        irq_src_d     = irq_src_q;
        irq_fire      = 1'b0;
`endif

        // Reply byte is on s_data the cycle after its strobe; ack replies are not kept.
        if (samp_q) begin
`ifdef SYSCTRL_MASTER_IRQ_SERVICE_EN
            if (internal_q) begin
                if (step_q == 2'd0) irq_pending_d = s_data;
                else if (step_q == 2'd1) irq_src_d = s_data;
            end else
`endif
            begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = s_data;
                rsp_index_d = samp_idx_q;
            end
        end

        case (state_q)
            S_IDLE: begin
`ifdef SYSCTRL_MASTER_IRQ_SERVICE_EN
                if (!int_sync_q) begin
                    cmd_d      = 8'h05;
                    len_d      = 4'd1;
                    payload_d  = '0;
                    internal_d = 1'b1;
                    step_d     = 2'd0;
                    state_d    = S_START;
                end else
`endif
                begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        cmd_d     = req_cmd;
                        len_d     = (req_len > LEN_MAX) ? LEN_MAX : req_len;
                        payload_d = req_payload;
                        state_d   = S_START;
                    end
                end
            end
            S_START: begin
                m_strobe = 1'b1;
                m_start  = 1'b1;
                m_data   = cmd_q;
                idx_d    = 4'd0;
                if (len_q == 4'd0) begin
                    cnt_d   = 4'd1;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d   = WAIT_LOAD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_BYTE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_BYTE: begin
                m_strobe   = 1'b1;
                m_data     = payload_q[{idx_q[2:0], 3'b000} +: 8];
                samp_d     = 1'b1;
                samp_idx_d = idx_q[2:0];
                if (idx_q + 4'd1 == len_q) begin
                    cnt_d   = 4'd1;
                    state_d = S_DRAIN;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    cnt_d   = WAIT_LOAD;
                    state_d = S_WAIT;
                end
            end
            S_DRAIN: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end
`ifdef SYSCTRL_MASTER_IRQ_SERVICE_EN
                else if (internal_q) begin
                    len_d     = 4'd1;
                    payload_d = '0;
                    state_d   = S_START;
                    case (step_q)
                        2'd0: begin
                            cmd_d  = 8'h06;
                            step_d = 2'd1;
                        end
                        2'd1: begin
                            if (irq_pending_q[0]) begin
                                cmd_d     = 8'h05;
                                payload_d = 64'h1;
                                step_d    = 2'd2;
                            end else begin
                                irq_fire   = 1'b1;
                                internal_d = 1'b0;
                                state_d    = S_IDLE;
                            end
                        end
                        default: begin
                            irq_fire   = 1'b1;
                            internal_d = 1'b0;
                            state_d    = S_IDLE;
                        end
                    endcase
                end
`endif
                else begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cmd_q       <= 8'h00;
            len_q       <= 4'd0;
            payload_q   <= '0;
            idx_q       <= 4'd0;
            cnt_q       <= 4'd0;
            samp_q      <= 1'b0;
            samp_idx_q  <= 3'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_index_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            len_q       <= len_d;
            payload_q   <= payload_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            samp_q      <= samp_d;
            samp_idx_q  <= samp_idx_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_index_q <= rsp_index_d;
        end
    end

`ifdef SYSCTRL_MASTER_IRQ_SERVICE_EN
    // Synchronizer resets to the inactive level so reset never launches a service sequence.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            int_meta_q    <= 1'b1;
            int_sync_q    <= 1'b1;
            internal_q    <= 1'b0;
            step_q        <= 2'd0;
            irq_pending_q <= 8'h00;
            irq_src_q     <= 8'h00;
        end else begin
            int_meta_q    <= s_int_n;
            int_sync_q    <= int_meta_q;
            internal_q    <= internal_d;
            step_q        <= step_d;
            irq_pending_q <= irq_pending_d;
            irq_src_q     <= irq_src_d;
        end
    end

    assign irq_valid   = irq_fire;
    assign irq_pending = irq_pending_q;
    assign irq_src     = irq_src_q;
`else
    assign irq_valid   = 1'b0;
    assign irq_pending = 8'h00;
    assign irq_src     = 8'h00;
`endif

    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_index = rsp_index_q;

endmodule

// File: tb/tb_sysctrl_master.sv
// Bench for sysctrl_master: responder model, cycle-exact frame schedule model, directed table, random frames.
module tb_sysctrl_master;
    localparam int G = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_cmd = 8'h00;
    logic [3:0]  req_len = 4'd0;
    logic [63:0] req_payload = '0;
    logic        m_strobe, m_start;
    logic [7:0]  m_data;
    logic [7:0]  s_data = 8'h00;
    logic        s_int_n;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic [2:0]  rsp_index;
    logic        done, busy, irq_valid;
    logic [7:0]  irq_pending, irq_src;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sysctrl_master #(.GAP(G), .MAXLEN(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_len(req_len), .req_payload(req_payload),
        .m_strobe(m_strobe), .m_start(m_start), .m_data(m_data),
        .s_data(s_data), .s_int_n(s_int_n),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_index(rsp_index),
        .done(done), .busy(busy),
        .irq_valid(irq_valid), .irq_pending(irq_pending), .irq_src(irq_src)
    );

    function automatic logic [7:0] ref_reply(input logic [7:0] cmd, input int k, input logic [7:0] b,
                                             input logic [7:0] pend, input logic [7:0] src);
        case (cmd)
            8'h00: begin
                if (k == 0) return 8'h5C;
                if (k == 1) return 8'h42;
                return 8'h00;
            end
            8'h04: return b;
            8'h05: return pend;
            8'h06: return src;
            default: return b ^ cmd ^ 8'(8'h11 * k);
        endcase
    endfunction

    // Responder: reply is valid on s_data only in the cycle after a byte strobe, garbage otherwise.
    logic [7:0]  r_cmd = 8'h00, r_key = 8'h00, scanlines = 8'h00;
    logic [7:0]  pending_r = 8'h00, irq_set = 8'h00;
    logic [7:0]  src_r = 8'h05;
    int          r_k = 0;
    logic [15:0] frame_log[$];

    always @(posedge clk) begin
        logic [7:0] ack;
        ack = 8'h00;
        if (m_strobe && m_start) begin
            r_cmd  <= m_data;
            r_k    <= 0;
            s_data <= 8'($urandom);
        end else if (m_strobe) begin
            s_data <= ref_reply(r_cmd, r_k, m_data, pending_r, src_r);
            r_k    <= r_k + 1;
            if (r_k == 0) begin
                r_key <= m_data;
                frame_log.push_back({r_cmd, m_data});
            end
            if (r_cmd == 8'h04 && r_k == 1 && r_key == 8'h53) scanlines <= m_data;
            if (r_cmd == 8'h05 && r_k == 0) ack = m_data;
        end else begin
            s_data <= 8'($urandom);
        end
        pending_r <= (pending_r | irq_set) & ~ack;
    end

    assign s_int_n = (pending_r == 8'h00);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_accept(input logic [7:0] cmd, input logic [3:0] len, input logic [63:0] pay);
        int n;
        n = 0;
        req_cmd = cmd; req_len = len; req_payload = pay; req_valid = 1'b1;
        while (req_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("accept", req_ready, 1);
    endtask

    // Called at the negedge of accept cycle T; checks every cycle up to the req_ready return.
    task automatic run_frame(input logic [7:0] cmd, input logic [3:0] len, input logic [63:0] pay,
                             input bit hold, input logic [7:0] ncmd, input logic [3:0] nlen,
                             input logic [63:0] npay, output int ns, output logic [63:0] got);
        int clen, last, i, j;
        logic e_str, e_st, e_rv, e_dn, e_bz, e_rd;
        logic [7:0] e_d, e_rdat, e_ri;
        clen = (len > 8) ? 8 : int'(len);
        last = 1 + clen * (G + 1);
        ns = 0;
        got = '0;
        for (int c = 1; c <= last + 3; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if (hold) begin
                    req_cmd = ncmd; req_len = nlen; req_payload = npay;
                end else begin
                    req_valid = 1'b0;
                end
            end
            e_str = 0; e_st = 0; e_d = 8'h00; e_rv = 0; e_rdat = 8'h00; e_ri = 8'h00;
            if ((c - 1) % (G + 1) == 0 && (c - 1) / (G + 1) <= clen) begin
                i = (c - 1) / (G + 1);
                e_str = 1;
                e_st = (i == 0);
                e_d = (i == 0) ? cmd : pay[8*(i-1) +: 8];
            end
            if (c >= 3 && (c - 3) % (G + 1) == 0) begin
                j = (c - 3) / (G + 1);
                if (j >= 1 && j <= clen) begin
                    e_rv = 1;
                    e_rdat = ref_reply(cmd, j - 1, pay[8*(j-1) +: 8], 8'h00, 8'h00);
                    e_ri = 8'(j - 1);
                end
            end
            e_dn = (c == last + 2);
            e_bz = (c <= last + 2);
            e_rd = (c == last + 3);
            chk($sformatf("frame_cmd%0h_c%0d", cmd, c),
                {m_strobe, m_start, m_data, rsp_valid, rsp_valid ? rsp_data : 8'h00,
                 rsp_valid ? {5'b0, rsp_index} : 8'h00, done, busy, req_ready},
                {e_str, e_st, e_d, e_rv, e_rdat, e_ri, e_dn, e_bz, e_rd});
            if (m_strobe) ns++;
            if (rsp_valid) got[int'(rsp_index)*8 +: 8] = rsp_data;
        end
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic [3:0]  len;
        logic [63:0] pay;
        int          exp_strobes;
        logic [63:0] exp_rsp;
        logic [7:0]  exp_scan;
    } vec_t;

    initial begin
        vec_t        vt[4];
        int          ns, cnt_r, cnt_d, cnt_s;
        logic [63:0] got;
        logic [7:0]  cmd;

        vt[0] = '{8'h00, 4'd3,  64'h0,                   4, 64'h0000_0000_0000_425C, 8'h00};
        vt[1] = '{8'h04, 4'd2,  64'h0253,                3, 64'h0000_0000_0000_0253, 8'h02};
        vt[2] = '{8'h01, 4'd0,  64'hFFFF_FFFF_FFFF_FFFF, 1, 64'h0,                   8'h02};
        vt[3] = '{8'h01, 4'd12, 64'h0,                   9, 64'h7667_5445_3223_1001, 8'h02};

        repeat (3) @(negedge clk);
        chk("rst_m_strobe", m_strobe, 0);
        chk("rst_m_start", m_start, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_rsp", {rsp_valid, rsp_data, rsp_index}, 0);
        chk("rst_done_busy", {done, busy}, 0);
        chk("rst_irq", {irq_valid, irq_pending, irq_src}, 0);
        chk("rst_req_ready", req_ready, 1);
        reset_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            wait_accept(vt[v].cmd, vt[v].len, vt[v].pay);
            run_frame(vt[v].cmd, vt[v].len, vt[v].pay, 0, 8'h00, 4'd0, 64'h0, ns, got);
            chk($sformatf("vec%0d_strobes", v), ns, vt[v].exp_strobes);
            chk($sformatf("vec%0d_rsp", v), got, vt[v].exp_rsp);
            chk($sformatf("vec%0d_scanlines", v), scanlines, vt[v].exp_scan);
            repeat (2) @(negedge clk);
        end

        // Back-to-back: valid stays high, second request taken the cycle after first done.
        wait_accept(8'h22, 4'd2, 64'h0000_0000_0000_A1B2);
        run_frame(8'h22, 4'd2, 64'h0000_0000_0000_A1B2, 1, 8'h33, 4'd1, 64'h0000_0000_0000_00C7, ns, got);
        run_frame(8'h33, 4'd1, 64'h0000_0000_0000_00C7, 0, 8'h00, 4'd0, 64'h0, ns, got);
        chk("b2b_second_rsp", got[7:0], 8'hC7 ^ 8'h33);
        @(negedge clk);

        // Reset during the WAIT following payload byte 1 of a len=5 frame.
        wait_accept(8'h10, 4'd5, 64'h0000_0055_4433_2211);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
            if (c == 9) chk("midrst_byte1", {m_strobe, m_data}, {1'b1, 8'h22});
        end
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_idle", {m_strobe, busy, req_ready, rsp_valid, done}, 5'b00100);
        reset_n = 1'b1;
        cnt_r = 0; cnt_d = 0; cnt_s = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            cnt_r += int'(rsp_valid); cnt_d += int'(done); cnt_s += int'(m_strobe);
        end
        chk("midrst_no_rsp", cnt_r, 0);
        chk("midrst_no_done", cnt_d, 0);
        chk("midrst_no_strobe", cnt_s, 0);

        for (int r = 0; r < 25; r++) begin
            logic [3:0]  ln;
            logic [63:0] py;
            cmd = 8'($urandom);
            if (cmd inside {[8'h04:8'h06]}) cmd = 8'h07;
            ln = 4'($urandom_range(0, 15));
            py = {32'($urandom), 32'($urandom)};
            repeat ($urandom_range(0, 3)) @(negedge clk);
            wait_accept(cmd, ln, py);
            run_frame(cmd, ln, py, 0, 8'h00, 4'd0, 64'h0, ns, got);
            chk($sformatf("rand%0d_strobes", r), ns, ((ln > 8) ? 8 : int'(ln)) + 1);
        end

        frame_log.delete();
        irq_set = 8'h01;
        @(negedge clk);
        irq_set = 8'h00;
`ifdef SYSCTRL_MASTER_IRQ_SERVICE_EN
        begin
            int nirq, bad_rdy;
            logic [7:0] ip, is;
            nirq = 0; bad_rdy = 0; cnt_r = 0; cnt_d = 0; ip = 8'h00; is = 8'h00;
            for (int c = 0; c < 120; c++) begin
                @(negedge clk);
                cnt_r += int'(rsp_valid); cnt_d += int'(done);
                if (busy && req_ready) bad_rdy++;
                if (irq_valid) begin
                    nirq++; ip = irq_pending; is = irq_src;
                end
            end
            chk("irq_valid_count", nirq, 1);
            chk("irq_pending", ip, 8'h01);
            chk("irq_src", is, 8'h05);
            chk("irq_no_rsp", cnt_r, 0);
            chk("irq_no_done", cnt_d, 0);
            chk("irq_ready_low", bad_rdy, 0);
            chk("irq_frames", frame_log.size(), 3);
            chk("irq_f0", (frame_log.size() > 0) ? frame_log[0] : 16'hFFFF, 16'h0500);
            chk("irq_f1", (frame_log.size() > 1) ? frame_log[1] : 16'hFFFF, 16'h0600);
            chk("irq_f2", (frame_log.size() > 2) ? frame_log[2] : 16'hFFFF, 16'h0501);
            chk("irq_line_cleared", s_int_n, 1);
        end
`else
        cnt_s = 0; cnt_d = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            cnt_s += int'(busy); cnt_d += int'(irq_valid);
        end
        chk("noirq_idle", cnt_s, 0);
        chk("noirq_valid", cnt_d, 0);
        chk("noirq_frames", frame_log.size(), 0);
        chk("noirq_regs", {irq_pending, irq_src}, 16'h0000);
`endif
        wait_accept(8'h09, 4'd2, 64'h0000_0000_0000_3C4D);
        run_frame(8'h09, 4'd2, 64'h0000_0000_0000_3C4D, 0, 8'h00, 4'd0, 64'h0, ns, got);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $fatal(1, "timeout");
    end
endmodule
